// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard unit and the 5-stage pipeline datapath.
// Slave is the hazard unit; master is the pipeline side.
interface pipe_hazard_ctrl_if #(
    parameter int RBUS = 32,
    parameter int REGW = 4,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [REGW-1:0] id_rs_a;
    logic [REGW-1:0] id_rs_b;
    logic            id_use_a;
    logic            id_use_b;
    logic [REGW-1:0] id_rd;
    logic            id_we;
    logic            id_is_load;
    logic [RBUS-1:0] rf_a;
    logic [RBUS-1:0] rf_b;
    logic [RBUS-1:0] ex_result;
    logic [RBUS-1:0] mem_result;
    logic [RBUS-1:0] mem_load_data;
    logic            mem_req;
    logic            mem_ready;
    logic [RBUS-1:0] wb_data;
    logic            ex_branch_taken;
    logic [RBUS-1:0] opa_fwd;
    logic [RBUS-1:0] opb_fwd;
    logic            stall_fetch;
    logic            flush_ifid;
    logic            bubble_idex;
    logic            freeze;
    logic            wb_commit;
    logic [REGW-1:0] wb_rd;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
        output id_rd, id_we, id_is_load, rf_a, rf_b,
        output ex_result, mem_result, mem_load_data,
        output mem_req, mem_ready, wb_data, ex_branch_taken,
        input  opa_fwd, opb_fwd, stall_fetch, flush_ifid,
        input  bubble_idex, freeze, wb_commit, wb_rd,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
        input  id_rd, id_we, id_is_load, rf_a, rf_b,
        input  ex_result, mem_result, mem_load_data,
        input  mem_req, mem_ready, wb_data, ex_branch_taken,
        output opa_fwd, opb_fwd, stall_fetch, flush_ifid,
        output bubble_idex, freeze, wb_commit, wb_rd,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control: EX/MEM/WB scoreboard, stall, flush,
// operand forwarding, memory-wait freeze and perf counters.
module pipe_hazard_ctrl #(
    parameter int RBUS     = 32,
    parameter int REGW     = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNTW     = 16
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic            we;
        logic [REGW-1:0] rd;
        logic            is_load;
    } slot_t;

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_wait, branch, load_use;
    logic ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
    logic stall_fetch, flush_ifid, bubble_idex;

    function automatic logic hit(slot_t s, logic [REGW-1:0] rs,
                                 logic use_i);
        return s.valid & s.we & (s.rd == rs) & use_i
             & ~(ZERO_REG & (rs == '0));
    endfunction

    always_comb begin
        ex_a  = hit(ex_q,  bus.id_rs_a, bus.id_use_a);
        mem_a = hit(mem_q, bus.id_rs_a, bus.id_use_a);
        wb_a  = hit(wb_q,  bus.id_rs_a, bus.id_use_a);
        ex_b  = hit(ex_q,  bus.id_rs_b, bus.id_use_b);
        mem_b = hit(mem_q, bus.id_rs_b, bus.id_use_b);
        wb_b  = hit(wb_q,  bus.id_rs_b, bus.id_use_b);
        mem_wait = mem_q.valid & bus.mem_req & ~bus.mem_ready;
        branch   = ex_q.valid & bus.ex_branch_taken & ~mem_wait;
        load_use = ex_q.is_load & bus.id_valid & (ex_a | ex_b)
                 & ~mem_wait & ~branch;
    end

    assign stall_fetch = ~rst & (mem_wait | load_use);
    assign flush_ifid  = ~rst & branch;
    assign bubble_idex = ~rst & (branch | load_use);

    assign bus.stall_fetch = stall_fetch;
    assign bus.flush_ifid  = flush_ifid;
    assign bus.bubble_idex = bubble_idex;
    assign bus.freeze      = ~rst & mem_wait;
    assign bus.wb_commit   = ~rst & wb_q.valid & wb_q.we;
    assign bus.wb_rd       = wb_q.rd;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

    // A load still in EX has no data yet; it is covered by the stall.
    always_comb begin
        bus.opa_fwd = bus.rf_a;
        if (!rst) begin
            if (ex_a && !ex_q.is_load)
                bus.opa_fwd = bus.ex_result;
            else if (mem_a)
                bus.opa_fwd = mem_q.is_load ? bus.mem_load_data
                                            : bus.mem_result;
            else if (wb_a)
                bus.opa_fwd = bus.wb_data;
        end
    end

    always_comb begin
        bus.opb_fwd = bus.rf_b;
        if (!rst) begin
            if (ex_b && !ex_q.is_load)
                bus.opb_fwd = bus.ex_result;
            else if (mem_b)
                bus.opb_fwd = mem_q.is_load ? bus.mem_load_data
                                            : bus.mem_result;
            else if (wb_b)
                bus.opb_fwd = bus.wb_data;
        end
    end

    // WB commits once on entry to a wait, then drains to a bubble.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (mem_wait) begin
            wb_d = '0;
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble_idex)
                ex_d = '0;
            else
                ex_d = {bus.id_valid, bus.id_we, bus.id_rd,
                        bus.id_is_load};
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fetch && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_ifid && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: cycle vector table plus
// hand-written memory-wait, reset-mid-wait and saturation sequences.
module tb_pipe_hazard_ctrl;
    localparam int RB = 32;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int RFA = 'h100;
    localparam int RFB = 'h200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RBUS(RB), .REGW(RW), .CNTW(CW)) bus ();

    pipe_hazard_ctrl #(
        .RBUS(RB), .REGW(RW), .ZERO_REG(1'b1), .CNTW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int idv, rsa, rsb, ua, ub, rd, we, ld;
        int exr, memr, mld, wbd;
        int mreq, mrdy, br;
        int e_opa, e_opb;
        int e_st, e_fl, e_bu, e_fz, e_cm, e_rd, e_sc, e_fc;
    } vec_t;

    vec_t tbl [13];
    int total = 0;
    int bad = 0;
    int commits;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_valid        = 1'b0;
        bus.id_rs_a         = '0;
        bus.id_rs_b         = '0;
        bus.id_use_a        = 1'b0;
        bus.id_use_b        = 1'b0;
        bus.id_rd           = '0;
        bus.id_we           = 1'b0;
        bus.id_is_load      = 1'b0;
        bus.rf_a            = RFA;
        bus.rf_b            = RFB;
        bus.ex_result       = '0;
        bus.mem_result      = '0;
        bus.mem_load_data   = '0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
        bus.wb_data         = '0;
        bus.ex_branch_taken = 1'b0;
    endtask

    task automatic dec(input logic [3:0] rd);
        idle();
        bus.id_valid = 1'b1;
        bus.id_rd    = rd;
        bus.id_we    = 1'b1;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        idle();
        nxt();
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.id_valid        = v.idv[0];
        bus.id_rs_a         = v.rsa[3:0];
        bus.id_rs_b         = v.rsb[3:0];
        bus.id_use_a        = v.ua[0];
        bus.id_use_b        = v.ub[0];
        bus.id_rd           = v.rd[3:0];
        bus.id_we           = v.we[0];
        bus.id_is_load      = v.ld[0];
        bus.rf_a            = RFA;
        bus.rf_b            = RFB;
        bus.ex_result       = v.exr;
        bus.mem_result      = v.memr;
        bus.mem_load_data   = v.mld;
        bus.wb_data         = v.wbd;
        bus.mem_req         = v.mreq[0];
        bus.mem_ready       = v.mrdy[0];
        bus.ex_branch_taken = v.br[0];
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.opa", i), bus.opa_fwd, v.e_opa);
        chk($sformatf("v%0d.opb", i), bus.opb_fwd, v.e_opb);
        chk($sformatf("v%0d.stall", i), 32'(bus.stall_fetch), v.e_st);
        chk($sformatf("v%0d.flush", i), 32'(bus.flush_ifid), v.e_fl);
        chk($sformatf("v%0d.bubble", i), 32'(bus.bubble_idex), v.e_bu);
        chk($sformatf("v%0d.freeze", i), 32'(bus.freeze), v.e_fz);
        chk($sformatf("v%0d.commit", i), 32'(bus.wb_commit), v.e_cm);
        if (v.e_cm != 0)
            chk($sformatf("v%0d.wb_rd", i), 32'(bus.wb_rd), v.e_rd);
        chk($sformatf("v%0d.scnt", i), 32'(bus.stall_cnt), v.e_sc);
        chk($sformatf("v%0d.fcnt", i), 32'(bus.flush_cnt), v.e_fc);
    endtask

    initial begin
        // idv rsa rsb ua ub rd we ld | exr memr mld wbd | mreq mrdy br
        // | opa opb | st fl bu fz cm wbrd scnt fcnt
        tbl[0]  = '{1,0,0,0,0,1,1,0, 0,0,0,0, 0,0,0,
                    RFA,RFB, 0,0,0,0,0,0,0,0};
        tbl[1]  = '{1,1,5,1,0,4,1,0, 5,0,0,0, 0,0,0,
                    5,RFB, 0,0,0,0,0,0,0,0};
        tbl[2]  = '{1,1,0,1,0,2,1,1, 'h77,5,0,0, 0,0,0,
                    5,RFB, 0,0,0,0,0,0,0,0};
        tbl[3]  = '{1,1,2,1,1,6,1,0, 'h66,'h44,0,'h11, 0,0,0,
                    'h11,RFB, 1,0,1,0,1,1,0,0};
        tbl[4]  = '{1,1,2,1,1,6,1,0, 'h66,'hDEAD,'hAB,'h11, 1,1,0,
                    RFA,'hAB, 0,0,0,0,1,4,1,0};
        tbl[5]  = '{1,0,0,0,0,3,1,1, 0,0,0,'h22, 0,0,0,
                    RFA,RFB, 0,0,0,0,1,2,1,0};
        tbl[6]  = '{1,3,0,1,0,7,1,0, 'h88,0,0,0, 0,0,1,
                    RFA,RFB, 0,1,1,0,0,0,1,0};
        tbl[7]  = '{0,7,3,1,1,0,0,0, 'h55,0,'h33,0, 0,0,0,
                    RFA,'h33, 0,0,0,0,1,6,1,1};
        tbl[8]  = '{1,0,0,0,0,0,1,0, 0,0,0,0, 0,0,0,
                    RFA,RFB, 0,0,0,0,1,3,1,1};
        tbl[9]  = '{1,0,0,1,1,3,1,0, 'h99,0,0,0, 0,0,0,
                    RFA,RFB, 0,0,0,0,0,0,1,1};
        tbl[10] = '{1,3,0,1,0,9,1,0, 'h3A,0,0,0, 0,0,0,
                    'h3A,RFB, 0,0,0,0,0,0,1,1};
        tbl[11] = '{1,3,0,1,0,3,1,0, 0,'h3B,0,0, 0,0,0,
                    'h3B,RFB, 0,0,0,0,1,0,1,1};
        tbl[12] = '{1,3,0,1,0,0,0,0, 7,0,0,9, 0,0,0,
                    7,RFB, 0,0,0,0,1,3,1,1};

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        nxt();
        bus.id_valid = 1'b1;
        bus.id_rs_a  = 4'd1;
        bus.id_use_a = 1'b1;
        bus.ex_branch_taken = 1'b1;
        bus.mem_req  = 1'b1;
        #1;
        chk("rst.opa", bus.opa_fwd, RFA);
        chk("rst.opb", bus.opb_fwd, RFB);
        chk("rst.stall", 32'(bus.stall_fetch), 0);
        chk("rst.flush", 32'(bus.flush_ifid), 0);
        chk("rst.bubble", 32'(bus.bubble_idex), 0);
        chk("rst.freeze", 32'(bus.freeze), 0);
        chk("rst.commit", 32'(bus.wb_commit), 0);
        chk("rst.scnt", 32'(bus.stall_cnt), 0);
        chk("rst.fcnt", 32'(bus.flush_cnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            nxt();
            apply(tbl[i]);
            #1;
            check_vec(i, tbl[i]);
        end

        do_reset();
        dec(4'd5);
        #1;
        chk("wait.fcnt_cleared", 32'(bus.flush_cnt), 0);
        nxt(); dec(4'd6);
        nxt(); dec(4'd7);
        commits = 0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            dec(4'd8);
            bus.mem_req = 1'b1;
            bus.ex_branch_taken = (k == 1);
            #1;
            chk($sformatf("wait%0d.freeze", k), 32'(bus.freeze), 1);
            chk($sformatf("wait%0d.stall", k), 32'(bus.stall_fetch), 1);
            chk($sformatf("wait%0d.flush", k), 32'(bus.flush_ifid), 0);
            chk($sformatf("wait%0d.bubble", k), 32'(bus.bubble_idex), 0);
            if (bus.wb_commit)
                commits++;
        end
        chk("wait.commits", commits, 1);
        nxt();
        dec(4'd8);
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b1;
        bus.id_rs_a   = 4'd7;
        bus.id_use_a  = 1'b1;
        bus.ex_result = 'h70;
        #1;
        chk("ready.freeze", 32'(bus.freeze), 0);
        chk("ready.stall", 32'(bus.stall_fetch), 0);
        chk("ready.opa", bus.opa_fwd, 'h70);
        chk("ready.scnt", 32'(bus.stall_cnt), 3);
        nxt();
        idle();
        #1;
        chk("resume.commit", 32'(bus.wb_commit), 1);
        chk("resume.wb_rd", 32'(bus.wb_rd), 6);

        do_reset();
        dec(4'd5);
        nxt(); idle();
        nxt(); idle();
        bus.mem_req = 1'b1;
        #1;
        chk("rstw.freeze_before", 32'(bus.freeze), 1);
        nxt();
        rst = 1'b1;
        idle();
        bus.mem_req  = 1'b1;
        bus.id_rs_a  = 4'd5;
        bus.id_use_a = 1'b1;
        bus.mem_result = 'h55;
        #1;
        chk("rstw.in_rst_freeze", 32'(bus.freeze), 0);
        chk("rstw.in_rst_commit", 32'(bus.wb_commit), 0);
        chk("rstw.in_rst_opa", bus.opa_fwd, RFA);
        nxt();
        rst = 1'b0;
        #1;
        chk("rstw.freeze", 32'(bus.freeze), 0);
        chk("rstw.stall", 32'(bus.stall_fetch), 0);
        chk("rstw.commit", 32'(bus.wb_commit), 0);
        chk("rstw.opa", bus.opa_fwd, RFA);
        chk("rstw.scnt", 32'(bus.stall_cnt), 0);
        chk("rstw.fcnt", 32'(bus.flush_cnt), 0);

        do_reset();
        dec(4'd5);
        nxt(); idle();
        for (int k = 0; k < 20; k++) begin
            nxt();
            idle();
            bus.mem_req = 1'b1;
        end
        nxt();
        idle();
        #1;
        chk("sat.scnt", 32'(bus.stall_cnt), 15);
        chk("sat.freeze_off", 32'(bus.freeze), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
